// File: rtl/min_reduce_pkg.sv
// Shared types and constants for the min-reduction controller.
// The all-ones identity is produced by a width-parameterised helper so that
// any WIDTH up to MAX_IDENTITY_W gets a correctly sized reset value for cur_min.
package min_reduce_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } min_reduce_state_t;

    localparam int MAX_IDENTITY_W = 256;

    // Returns a vector whose low 'width' bits are set; callers cast it to their width.
    function automatic logic [MAX_IDENTITY_W-1:0] all_ones(input int width);
        logic [MAX_IDENTITY_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_IDENTITY_W; i++) begin
            if (i < width) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/gt_uint_nbit.sv
// Unsigned greater-than comparator shared with the pairwise min kernels.
// Purely combinational: gt = (a > b) over the full WIDTH.
module gt_uint_nbit #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt
);

    assign gt = (a > b);

endmodule

// File: rtl/min_reduce_uint_ctrl.sv
// Streaming minimum reduction over a length-programmed burst of unsigned words.
// One element per cycle is accepted in ACCUM; the result is held in DONE until
// the consumer takes it.
// Optional feature: define MIN_REDUCE_ARGMIN_EN to add the out_idx port and the
// index register that tracks the first position of the minimum.
module min_reduce_uint_ctrl
    import min_reduce_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COUNT_W-1:0] len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_min,
`ifdef MIN_REDUCE_ARGMIN_EN
    output logic [COUNT_W-1:0] out_idx,
`endif
    output logic               busy
);

    localparam logic [WIDTH-1:0] IDENTITY = WIDTH'(all_ones(WIDTH));

    min_reduce_state_t state;
    min_reduce_state_t next_state;

    logic [COUNT_W-1:0] len_reg;
    logic [COUNT_W-1:0] count;
    logic [WIDTH-1:0]   min_reg;
    logic               cur_gt_in;
    logic               accept;
    logic               last_elem;
    logic               take;

    // cur_min lives in the result register; it is only meaningful to the
    // consumer once out_valid is high, so no separate output copy is needed.
    assign out_min = min_reg;

    gt_uint_nbit #(
        .WIDTH(WIDTH)
    ) u_gt (
        .a (min_reg),
        .b (in_data),
        .gt(cur_gt_in)
    );

    assign accept    = in_valid && in_ready;
    assign last_elem = (count == (len_reg - COUNT_W'(1)));
    // The first element always loads, which also covers an all-ones first value
    // that would otherwise tie with the identity and be skipped.
    assign take      = accept && (cur_gt_in || (count == '0));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; handshake outputs decode from the registered state only.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state = (len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && last_elem) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
                busy       = 1'b0;
            end
        endcase
    end

    // Burst length, element counter and running minimum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_reg <= '0;
            count   <= '0;
            min_reg <= '0;
        end else if ((state == IDLE) && start) begin
            len_reg <= len;
            count   <= '0;
            min_reg <= IDENTITY;
        end else if (accept) begin
            count <= count + COUNT_W'(1);
            if (take) begin
                min_reg <= in_data;
            end
        end
    end

`ifdef MIN_REDUCE_ARGMIN_EN
    // Position of the minimum; strict greater-than keeps the first occurrence on ties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_idx <= '0;
        end else if ((state == IDLE) && start) begin
            out_idx <= '0;
        end else if (take) begin
            out_idx <= count;
        end
    end
`endif

endmodule

// File: tb/tb_min_reduce_uint_ctrl.sv
// Self-checking bench for min_reduce_uint_ctrl: a table of directed bursts,
// hand-written backpressure and reset-abort sequences, then randomized bursts
// scored against a simple list-minimum model.
// Define MIN_REDUCE_ARGMIN_EN to also check out_idx.
module tb_min_reduce_uint_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] len;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_min;
`ifdef MIN_REDUCE_ARGMIN_EN
    logic [15:0] out_idx;
`endif
    logic        busy;

    int checks;
    int errors;

    logic [31:0] feed[$];

    typedef struct {
        int          n;
        logic [31:0] d[8];
        int          gap;
        logic [31:0] exp_min;
        int          exp_idx;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] exp_min;
    int          exp_idx;

    min_reduce_uint_ctrl #(
        .WIDTH  (32),
        .COUNT_W(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_min  (out_min),
`ifdef MIN_REDUCE_ARGMIN_EN
        .out_idx  (out_idx),
`endif
        .busy     (busy)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the DUT wedges somewhere the bounded waits do not cover.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Minimum of the list and the first index holding it.
    task automatic refModel(output logic [31:0] m, output int idx);
        m   = 32'hFFFF_FFFF;
        idx = 0;
        foreach (feed[i]) begin
            if (i == 0 || feed[i] < m) begin
                m   = feed[i];
                idx = i;
            end
        end
    endtask

    // Issues start and pushes the contents of feed; leaves the DUT in DONE.
    // gap < 0 selects random idle cycles between elements.
    task automatic applyStimulus(input int n, input int gap);
        int   accepted;
        int   budget;
        int   wait_left;
        int   cycles;
        logic will_accept;
        accepted  = 0;
        wait_left = 0;
        cycles    = 0;
        budget    = n * 8 + 20;
        start     = 1'b1;
        len       = 16'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
        if (n == 0) begin
            checkOutput("len0_out_valid", out_valid, 1);
            checkOutput("len0_in_ready", in_ready, 0);
            return;
        end
        checkOutput("start_in_ready", in_ready, 1);
        checkOutput("start_busy", busy, 1);
        while (accepted < n && budget > 0) begin
            if (wait_left > 0) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                wait_left--;
            end else begin
                in_valid = 1'b1;
                in_data  = feed[accepted];
            end
            will_accept = in_valid && in_ready;
            @(posedge clk);
            #1;
            budget--;
            cycles++;
            if (will_accept) begin
                accepted++;
                wait_left = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            end
            if (accepted < n) begin
                checkOutput("accum_in_ready", in_ready, 1);
                checkOutput("accum_out_valid", out_valid, 0);
            end
        end
        in_valid = 1'b0;
        checkOutput("burst_accepted", accepted, n);
        if (gap == 0) begin
            checkOutput("b2b_cycles", cycles, n);
        end
        checkOutput("done_out_valid", out_valid, 1);
        checkOutput("done_in_ready", in_ready, 0);
    endtask

    // Holds out_ready low for 'hold' cycles, optionally pulsing start, then releases.
    task automatic releaseResult(input int hold, input bit pulse_start, input logic [31:0] m);
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            if (pulse_start && i == 1) begin
                start = 1'b1;
                len   = 16'd3;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            checkOutput("hold_out_valid", out_valid, 1);
            checkOutput("hold_out_min", out_min, m);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("release_out_valid", out_valid, 0);
        checkOutput("release_busy", busy, 0);
        checkOutput("release_in_ready", in_ready, 0);
    endtask

    task automatic checkResult(input string tag, input logic [31:0] m, input int idx);
        checkOutput({tag, "_out_min"}, out_min, m);
`ifdef MIN_REDUCE_ARGMIN_EN
        checkOutput({tag, "_out_idx"}, out_idx, idx);
`endif
    endtask

    // Main sequence.
    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        vecs[0] = '{4, '{32'd7, 32'd3, 32'd9, 32'd3, 0, 0, 0, 0}, 0, 32'd3, 1};
        vecs[1] = '{0, '{0, 0, 0, 0, 0, 0, 0, 0}, 0, 32'hFFFF_FFFF, 0};
        vecs[2] = '{3, '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 0, 0, 0, 0, 0}, 2, 32'd0, 2};
        vecs[3] = '{1, '{32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0}, 0, 32'hFFFF_FFFF, 0};
        vecs[4] = '{5, '{32'd10, 32'd9, 32'd8, 32'h8000_0000, 32'd8, 0, 0, 0}, 1, 32'd8, 2};
        vecs[5] = '{8, '{32'h8000_0001, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'd100, 32'd100,
                         32'h0000_0065, 32'hFFFF_0000, 32'd99}, 0, 32'd99, 7};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", in_ready, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkResult("reset", 32'd0, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] directed table");
        for (int v = 0; v < 6; v++) begin
            feed.delete();
            for (int i = 0; i < vecs[v].n; i++) begin
                feed.push_back(vecs[v].d[i]);
            end
            applyStimulus(vecs[v].n, vecs[v].gap);
            checkResult($sformatf("vec%0d", v), vecs[v].exp_min, vecs[v].exp_idx);
            releaseResult(0, 1'b0, vecs[v].exp_min);
        end

        $display("[TB] backpressure with start during DONE");
        feed = '{32'd40, 32'd12, 32'd33};
        applyStimulus(3, 0);
        checkResult("bp", 32'd12, 1);
        releaseResult(5, 1'b1, 32'd12);
        checkOutput("bp_idle_after", busy, 0);

        $display("[TB] reset mid-burst");
        start = 1'b1;
        len   = 16'd8;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'd50 + 32'(i);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checkOutput("pre_abort_out_min", out_min, 32'd50);
        rst = 1'b1;
        #1;
        checkOutput("abort_in_ready", in_ready, 0);
        checkOutput("abort_out_valid", out_valid, 0);
        checkOutput("abort_busy", busy, 0);
        checkResult("abort", 32'd0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        feed = '{32'd5, 32'd6};
        applyStimulus(2, 0);
        checkResult("post_abort", 32'd5, 0);
        releaseResult(1, 1'b0, 32'd5);

        $display("[TB] randomized bursts");
        for (int r = 0; r < 25; r++) begin
            int n;
            n = int'($urandom_range(1, 12));
            feed.delete();
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 3))
                    0:       feed.push_back(32'hFFFF_FFFF);
                    1:       feed.push_back($urandom);
                    default: feed.push_back(32'($urandom_range(0, 20)));
                endcase
            end
            refModel(exp_min, exp_idx);
            applyStimulus(n, -1);
            checkResult($sformatf("rand%0d", r), exp_min, exp_idx);
            releaseResult(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), exp_min);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/min_reduce_uint_ctrl.md
# min_reduce_uint_ctrl

Sequential controller that reduces a stream of unsigned WIDTH-bit words to their minimum. It sequences one `gt_uint_nbit` comparator across a length-programmed burst, accepting one element per cycle over a valid/ready input. It presents the result on a held valid/ready output. It sits between a host/command port and the benchmark datapath, reusing the same greater-than primitive as the pairwise min kernels.

## Interface
- `WIDTH`, 32, element width in bits
- `COUNT_W`, 16, width of length and index fields
- `clk`  input  1  rising-edge clock
- `rst`  input  1  asynchronous, active-high reset
- `start`  input  1  single-cycle command pulse; sampled only in IDLE
- `len`  input  COUNT_W  element count for the burst; captured with `start`
- `in_valid`  input  1  element valid
- `in_ready`  output  1  element accepted when `in_valid && in_ready`
- `in_data`  input  WIDTH  element value
- `out_valid`  output  1  result valid; held until accepted
- `out_ready`  input  1  result consumer ready
- `out_min`  output  WIDTH  minimum of the burst
- `out_idx`  output  COUNT_W  position of the minimum (ARGMIN_EN only)
- `busy`  output  1  high in every state except IDLE

## Operation
- Reset is asynchronous and active-high. All registers clear: state=IDLE, `in_ready`=0, `out_valid`=0, `busy`=0, `out_min`=0, `out_idx`=0, element counter=0.
- State machine has three states: IDLE, ACCUM, DONE.
- IDLE + `start`, `len`≠0:
  - capture `len`, clear the counter
  - load `cur_min` = all-ones (identity)
  - go to ACCUM
- IDLE + `start`, `len`=0:
  - go directly to DONE
  - `out_min` = all-ones, `out_idx` = 0
- ACCUM:
  - `in_ready`=1.
  - On each accepted element, `cur_min` is replaced when comparator(A=`cur_min`, B=`in_data`) reports A>B.
  - The first element always loads, because the identity compares ≥ any value. A first element equal to all-ones loads via the counter==0 override.
  - Ties keep the earlier element, so `out_idx` reports the first occurrence.
  - The counter increments per accept. When the accept occurs with counter==`len`−1, go to DONE.
- DONE:
  - `out_valid`=1 with `out_min`/`out_idx` stable.
  - On `out_ready`, go to IDLE and drop `out_valid`.
- `start` outside IDLE is ignored, with no effect on the burst in flight. `len` is only sampled on an accepted `start`.
- `in_valid` outside ACCUM is not accepted (`in_ready`=0); data is ignored.
- Arithmetic: the comparison is unsigned, full WIDTH, with no truncation. The counter is COUNT_W bits, so the maximum burst is 2^COUNT_W−1 elements. The counter never wraps within a burst.
- Reset mid-burst aborts immediately. Partial results are discarded and no `out_valid` is emitted.

## Timing
- Throughput: one element per cycle in ACCUM. The comparator is combinational between `cur_min` and `in_data`, with no internal pipeline.
- `start` in cycle T: `in_ready` rises in T+1, or `out_valid` rises in T+1 for `len`=0.
- Last element accepted in cycle T: `out_valid` rises in T+1.
- Total latency for N back-to-back elements is N+1 cycles from the first `in_ready`.
- `out_valid` && `out_ready` in cycle T: IDLE in T+1. A new `start` is accepted no earlier than T+1.
- `in_ready` depends only on state (no combinational path from `in_valid`). `out_valid` is registered.

## Configuration
- Macro: `MIN_REDUCE_ARGMIN_EN`.
- Defined: index tracking is present.
  - `out_idx` port exists.
  - An index register updates alongside `cur_min` with the counter value at replacement.
  - Tie rule is first occurrence.
- Undefined: `out_idx` port and index register are absent. Min-value behaviour and timing are identical.

## Structure
- Shared package `min_reduce_pkg` holds:
  - state typedef `min_reduce_state_t` {IDLE, ACCUM, DONE}
  - constant for the all-ones identity, parameterised by WIDTH via function
- Sub-module: one instance of the existing `gt_uint_nbit` (WIDTH=`WIDTH`) as the comparator. No other sub-modules.
- Controller FSM, counter and result registers live in the top module.

## Test plan
- `len`=4, data 7,3,9,3 back-to-back → `out_valid` one cycle after last accept; `out_min`=3; `out_idx`=1 (first occurrence).
- `len`=0 → `out_valid` in cycle after `start`; `out_min`=0xFFFFFFFF; `out_idx`=0; `in_ready` never asserts.
- `len`=3, data 0xFFFFFFFF,0xFFFFFFFF,0x00000000 with `in_valid` gaps of 2 cycles → `out_min`=0, `out_idx`=2; `in_ready` held high through gaps.
- Result backpressure: `out_ready` low for 5 cycles → `out_valid`/`out_min` stable. A `start` pulsed during DONE is ignored. Return to IDLE one cycle after `out_ready`.
- `start` with `len`=8, assert `rst` after 3 accepts → all outputs 0 immediately. A fresh burst `len`=2 (5,6) after deassert → `out_min`=5, `out_idx`=0.
- Compile without `MIN_REDUCE_ARGMIN_EN`: rerun scenario 1 → `out_min`=3, same timing, no `out_idx` port.
